dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the CPU load/store path and port 1 is the host/debug access path.
- Performs round-robin arbitration with an optional fixed CPU priority.
- Drives registered address, write-data and write-enable to the memory and returns read data with a fixed latency.
- Sits between the CPU core, the host interface and the data-memory wrapper, which has a synchronous read with one cycle of latency.

Parameters:
ADDR_W, 9, word-address width (512 words)
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins a conflict

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
req0  input  1  port 0 request; held until gnt0
we0  input  1  port 0 write (1) / read (0)
addr0  input  ADDR_W  port 0 word address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 grant pulse
rvalid0  output  1  port 0 read data valid
rdata0  output  DATA_W  port 0 read data
req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  port 1 request group, same meaning as port 0
gnt1, rvalid1, rdata1  output  1/1/DATA_W  port 1 response group, same meaning as port 0
mem_addr  output  ADDR_W  memory address (registered)
mem_wdata  output  DATA_W  memory write data (registered)
mem_we  output  1  memory write enable (registered)
mem_rdata  input  DATA_W  memory read data, valid one cycle after the address is presented
busy  output  1  an operation is issued or a read is in flight

Behaviour:
- Reset: gnt0/1=0, rvalid0/1=0, mem_we=0, mem_addr=0, mem_wdata=0, last_winner=1 (port 0 wins the first round-robin conflict). Any in-flight read is discarded and no rvalid is produced after reset.
- Handshake: a requester holds req/we/addr/wdata stable from assertion until it sees gnt high. It may change or deassert them on the clock edge that ends the gnt cycle.
- Arbitration happens every rising edge E. Eligible port = reqX high and gntX currently low; a port granted at E is ineligible at E+1, which prevents a double grant on its still-high request.
- Winner selection:
  - One eligible port: it wins.
  - Two eligible, FIXED_PRIO=1: port 0 wins.
  - Two eligible, FIXED_PRIO=0: the port != last_winner wins.
  - last_winner updates on every grant.
- On a win at edge E:
  - mem_addr/mem_wdata/mem_we are loaded from the winner.
  - gntX goes high for exactly one cycle (E to E+1).
  - With no winner, mem_we=0 and mem_addr/mem_wdata hold their previous value.
- Write: the memory commits at E+1 (mem_we high for exactly one cycle). No rvalid is generated.
- Read: a read-pending flag and the port id are registered at E. rvalidX is high for one cycle from E+1 to E+2, and rdataX = mem_rdata combinationally during that cycle.
- Latency: request seen at E gives gnt during cycle E..E+1 and read data during E+1..E+2.
- rdataX when not valid: drives mem_rdata; consumers qualify it with rvalidX only.
- Throughput:
  - One op per cycle when both ports alternate.
  - A single port achieves one op per two cycles.
  - Grants pipeline under in-flight reads: a new grant may issue in the cycle rvalid is high.
- Ordering: a write granted at E followed by a read of the same address granted at E+1 returns the new data, because the memory writes before reading the next address.
- busy = gnt0|gnt1|rvalid0|rvalid1.
- Reset asserted mid-operation clears everything immediately (asynchronous). Requesters re-present their request after reset deasserts.

Test Plan:
- Reset, idle: rst pulse with no req → all gnt/rvalid/mem_we=0, busy=0.
- Port 0 alone: write addr 5 = 0xDEADBEEF, then read addr 5 → gnt0 one cycle, mem_we pulse once, rvalid0 two cycles after req with rdata0=0xDEADBEEF.
- Simultaneous requests, FIXED_PRIO=0: both req at the same edge, reads of addrs 1/2 → port 0 granted first, port 1 next cycle; rvalid0 then rvalid1 on consecutive cycles with the correct data. Repeat with both held continuously → strict alternation for ≥8 grants.
- FIXED_PRIO=1 contention: port 0 issues a request every other cycle while req1 is held → port 1 is granted only in cycles where port 0 is ineligible; no port 0 request waits more than 1 cycle.
- Cross-port coherency: port 1 writes 0x12345678 to addr 511 (address wrap boundary), port 0 reads addr 511 in the next cycle → rdata0=0x12345678.
- Reset during an in-flight read: assert rst in the gnt cycle of a read → no rvalid afterwards, mem_we=0. After release, a fresh request completes normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin / fixed-priority arbiter for the data-memory port
module dmem_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    logic elig0;
    logic elig1;
    logic win0;
    logic win1;
    logic last_winner;
    logic rd_pend;
    logic rd_port;

    // A port holding gnt this cycle is ineligible so its still-high request is not granted twice.
    always_comb begin
        elig0 = bus.req0 & ~bus.gnt0;
        elig1 = bus.req1 & ~bus.gnt1;
        win0  = elig0 & (~elig1 | (FIXED_PRIO != 0) | last_winner);
        win1  = elig1 & ~win0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            last_winner   <= 1'b1;
            rd_pend       <= 1'b0;
            rd_port       <= 1'b0;
        end else begin
            bus.gnt0   <= win0;
            bus.gnt1   <= win1;
            bus.mem_we <= (win0 & bus.we0) | (win1 & bus.we1);
            if (win0) begin
                bus.mem_addr  <= bus.addr0;
                bus.mem_wdata <= bus.wdata0;
            end else if (win1) begin
                bus.mem_addr  <= bus.addr1;
                bus.mem_wdata <= bus.wdata1;
            end
            if (win0 | win1) begin
                last_winner <= win1;
            end
            // Memory returns data one cycle after the address, so rvalid trails the grant by one.
            rd_pend     <= (win0 & ~bus.we0) | (win1 & ~bus.we1);
            rd_port     <= win1;
            bus.rvalid0 <= rd_pend & ~rd_port;
            bus.rvalid1 <= rd_pend & rd_port;
        end
    end

    assign bus.rdata0 = bus.mem_rdata;
    assign bus.rdata1 = bus.mem_rdata;
    assign bus.busy   = bus.gnt0 | bus.gnt1 | bus.rvalid0 | bus.rvalid1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter in round-robin and fixed-priority builds
module tb_dmem_arbiter;
    typedef struct {
        logic        req0;
        logic        we0;
        logic [8:0]  addr0;
        logic [31:0] wdata0;
        logic        req1;
        logic        we1;
        logic [8:0]  addr1;
        logic [31:0] wdata1;
        logic        gnt0;
        logic        gnt1;
        logic        mem_we;
        logic [8:0]  mem_addr;
        logic        rvalid0;
        logic        rvalid1;
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [8:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    int n_chk  = 0;
    int n_fail = 0;
    vec_t vq[$];

    logic [31:0] mem_rr [512];
    logic [31:0] mem_fx [512];
    logic [31:0] rd_rr, rd_fx;

    logic fr0 [8];
    logic fr1 [8];
    logic eg0 [8];
    logic eg1 [8];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) if_rr ();
    dmem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) if_fx ();

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRIO(1)) dut_fx (.clk(clk), .rst(rst), .bus(if_fx.slave));

    assign if_rr.req0 = req0;  assign if_rr.we0 = we0;  assign if_rr.addr0 = addr0;  assign if_rr.wdata0 = wdata0;
    assign if_rr.req1 = req1;  assign if_rr.we1 = we1;  assign if_rr.addr1 = addr1;  assign if_rr.wdata1 = wdata1;
    assign if_fx.req0 = req0;  assign if_fx.we0 = we0;  assign if_fx.addr0 = addr0;  assign if_fx.wdata0 = wdata0;
    assign if_fx.req1 = req1;  assign if_fx.we1 = we1;  assign if_fx.addr1 = addr1;  assign if_fx.wdata1 = wdata1;
    assign if_rr.mem_rdata = rd_rr;
    assign if_fx.mem_rdata = rd_fx;

    // Synchronous read-first memories, one per arbiter instance.
    always @(posedge clk) begin
        if (if_rr.mem_we) mem_rr[if_rr.mem_addr] <= if_rr.mem_wdata;
        rd_rr <= mem_rr[if_rr.mem_addr];
        if (if_fx.mem_we) mem_fx[if_fx.mem_addr] <= if_fx.mem_wdata;
        rd_fx <= mem_fx[if_fx.mem_addr];
    end

    function automatic logic [31:0] m(input int i);
        return 32'hA000_0000 | i;
    endfunction

    function automatic vec_t v(input logic r0, input logic w0, input logic [8:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [8:0] a1, input logic [31:0] d1,
                               input logic g0, input logic g1, input logic mw, input logic [8:0] ma,
                               input logic rv0, input logic rv1, input logic [31:0] rd, input logic bsy);
        vec_t t;
        t.req0 = r0; t.we0 = w0; t.addr0 = a0; t.wdata0 = d0;
        t.req1 = r1; t.we1 = w1; t.addr1 = a1; t.wdata1 = d1;
        t.gnt0 = g0; t.gnt1 = g1; t.mem_we = mw; t.mem_addr = ma;
        t.rvalid0 = rv0; t.rvalid1 = rv1; t.rdata = rd; t.busy = bsy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_rr[i] = m(i);
            mem_fx[i] = m(i);
        end
        fr0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        fr1 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eg0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        eg1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Simultaneous reads from reset: port 0 first, then port 1.
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd0,   0,0,32'h0,1));
        vq[0].busy = 1'b0;
        vq.push_back(v(1,0,9'd1,32'h0,   1,0,9'd2,32'h0,  1,0,0,9'd1,   0,0,32'h0,1));
        vq.push_back(v(0,0,9'd0,32'h0,   1,0,9'd2,32'h0,  0,1,0,9'd2,   1,0,m(1),1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd2,   0,1,m(2),1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd2,   0,0,32'h0,0));
        // Both held continuously: strict alternation.
        for (int k = 1; k <= 8; k++)
            vq.push_back(v(1,0,9'd3,32'h0, 1,0,9'd4,32'h0, (k%2)==1, (k%2)==0, 0, ((k%2)==1) ? 9'd3 : 9'd4,
                           (k%2)==0, ((k%2)==1) && (k>1), ((k%2)==0) ? m(3) : m(4), 1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd4,   0,1,m(4),1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd4,   0,0,32'h0,0));
        // Port 0 alone: write then read, then held read at one op per two cycles.
        vq.push_back(v(1,1,9'd5,32'hDEADBEEF, 0,0,9'd0,32'h0, 1,0,1,9'd5, 0,0,32'h0,1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd5,   0,0,32'h0,0));
        vq.push_back(v(1,0,9'd5,32'h0,   0,0,9'd0,32'h0,  1,0,0,9'd5,   0,0,32'h0,1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd5,   1,0,32'hDEADBEEF,1));
        vq.push_back(v(1,0,9'd5,32'h0,   0,0,9'd0,32'h0,  1,0,0,9'd5,   0,0,32'h0,1));
        vq.push_back(v(1,0,9'd5,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd5,   1,0,32'hDEADBEEF,1));
        vq.push_back(v(1,0,9'd5,32'h0,   0,0,9'd0,32'h0,  1,0,0,9'd5,   0,0,32'h0,1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd5,   1,0,32'hDEADBEEF,1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd5,   0,0,32'h0,0));
        // Cross-port coherency at the top address.
        vq.push_back(v(0,0,9'd0,32'h0,   1,1,9'd511,32'h12345678, 0,1,1,9'd511, 0,0,32'h0,1));
        vq.push_back(v(1,0,9'd511,32'h0, 0,0,9'd0,32'h0,  1,0,0,9'd511, 0,0,32'h0,1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd511, 1,0,32'h12345678,1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd511, 0,0,32'h0,0));
        // Port 0 won last, so a fresh conflict goes to port 1.
        vq.push_back(v(1,0,9'd1,32'h0,   1,0,9'd2,32'h0,  0,1,0,9'd2,   0,0,32'h0,1));
        vq.push_back(v(1,0,9'd1,32'h0,   0,0,9'd0,32'h0,  1,0,0,9'd1,   0,1,m(2),1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd1,   1,0,m(1),1));
        vq.push_back(v(0,0,9'd0,32'h0,   0,0,9'd0,32'h0,  0,0,0,9'd1,   0,0,32'h0,0));

        // Reset state while rst is held.
        #1;
        chk("rst gnt0",      if_rr.gnt0, 0);
        chk("rst gnt1",      if_rr.gnt1, 0);
        chk("rst rvalid0",   if_rr.rvalid0, 0);
        chk("rst rvalid1",   if_rr.rvalid1, 0);
        chk("rst mem_we",    if_rr.mem_we, 0);
        chk("rst mem_addr",  if_rr.mem_addr, 0);
        chk("rst mem_wdata", if_rr.mem_wdata, 0);
        chk("rst busy",      if_rr.busy, 0);
        step();
        step();
        rst = 1'b0;

        foreach (vq[i]) begin
            req0 = vq[i].req0; we0 = vq[i].we0; addr0 = vq[i].addr0; wdata0 = vq[i].wdata0;
            req1 = vq[i].req1; we1 = vq[i].we1; addr1 = vq[i].addr1; wdata1 = vq[i].wdata1;
            step();
            chk($sformatf("v%0d gnt0", i),     if_rr.gnt0,     vq[i].gnt0);
            chk($sformatf("v%0d gnt1", i),     if_rr.gnt1,     vq[i].gnt1);
            chk($sformatf("v%0d mem_we", i),   if_rr.mem_we,   vq[i].mem_we);
            chk($sformatf("v%0d mem_addr", i), if_rr.mem_addr, vq[i].mem_addr);
            chk($sformatf("v%0d rvalid0", i),  if_rr.rvalid0,  vq[i].rvalid0);
            chk($sformatf("v%0d rvalid1", i),  if_rr.rvalid1,  vq[i].rvalid1);
            chk($sformatf("v%0d busy", i),     if_rr.busy,     vq[i].busy);
            if (vq[i].rvalid0) chk($sformatf("v%0d rdata0", i), if_rr.rdata0, vq[i].rdata);
            if (vq[i].rvalid1) chk($sformatf("v%0d rdata1", i), if_rr.rdata1, vq[i].rdata);
        end

        // Fixed priority: port 0 every other cycle against a held port 1.
        idle_inputs();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            req0 = fr0[i]; addr0 = 9'd6; req1 = fr1[i]; addr1 = 9'd7;
            step();
            chk($sformatf("fx%0d gnt0", i), if_fx.gnt0, eg0[i]);
            chk($sformatf("fx%0d gnt1", i), if_fx.gnt1, eg1[i]);
            if (i == 1) begin
                chk("fx1 rvalid0", if_fx.rvalid0, 1);
                chk("fx1 rdata0",  if_fx.rdata0, m(6));
            end
            if (i == 2) begin
                chk("rr conflict gnt0", if_rr.gnt0, 0);
                chk("rr conflict gnt1", if_rr.gnt1, 1);
            end
        end
        idle_inputs();
        step();
        step();

        // Reset during the grant cycle of a read.
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'd5;
        step();
        chk("mid gnt0 before rst", if_rr.gnt0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst gnt0",   if_rr.gnt0, 0);
        chk("mid rst busy",   if_rr.busy, 0);
        chk("mid rst mem_we", if_rr.mem_we, 0);
        req0 = 1'b0;
        #2;
        rst = 1'b0;
        step();
        chk("post rst rvalid0 a", if_rr.rvalid0, 0);
        chk("post rst mem_we a",  if_rr.mem_we, 0);
        step();
        chk("post rst rvalid0 b", if_rr.rvalid0, 0);
        chk("post rst busy b",    if_rr.busy, 0);
        req0 = 1'b1; addr0 = 9'd5;
        step();
        chk("fresh gnt0", if_rr.gnt0, 1);
        req0 = 1'b0;
        step();
        chk("fresh rvalid0", if_rr.rvalid0, 1);
        chk("fresh rdata0",  if_rr.rdata0, 32'hDEADBEEF);
        step();
        chk("fresh busy", if_rr.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
